reg_file_wr_arbiter: RTL and testbench

Shares the single register-file write port (Rd, Wdata, w_enable) between two requesters: port 0 is ALU writeback and port 1 is the load/IO path.
- Each port has a small FIFO with a valid/ready handshake.
- A round-robin arbiter drains the FIFOs into registered write signals that drive reg_file directly.
- Writes to register 0 are consumed and dropped here, so the zero register is never written.

---
 rtl/reg_file_wr_arbiter_pkg.sv | 17 +
 rtl/reg_file_wr_arbiter_if.sv | 37 +++
 rtl/reg_file_wr_arbiter_fifo.sv | 49 ++++
 rtl/reg_file_wr_arbiter.sv | 92 +++++++++
 tb/tb_reg_file_wr_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/reg_file_wr_arbiter_pkg.sv
// Shared types for the register-file write-port arbiter.
// One write request is a destination register plus its data.
package reg_arb_pkg;

    localparam int N         = 8;
    localparam int M         = 32;
    localparam int ADDR_W    = $clog2(M);
    localparam int NUM_PORTS = 2;

    localparam logic [ADDR_W-1:0] ZERO_REG = '0;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [N-1:0]      data;
    } wr_req_t;

endpackage

// File: rtl/reg_file_wr_arbiter_if.sv
// Requester handshakes and reg_file write bus of the write-port arbiter.
// master = requesters and reg_file side, slave = the arbiter.
interface reg_file_wr_arbiter_if
    import reg_arb_pkg::*;
;
    logic              req0_valid;
    logic              req0_ready;
    logic [ADDR_W-1:0] req0_addr;
    logic [N-1:0]      req0_data;

    logic              req1_valid;
    logic              req1_ready;
    logic [ADDR_W-1:0] req1_addr;
    logic [N-1:0]      req1_data;

    logic [ADDR_W-1:0] Rd;
    logic [N-1:0]      Wdata;
    logic              w_enable;
    logic              grant_id;
    logic              r0_drop;
    logic              busy;

    modport master (
        output req0_valid, req0_addr, req0_data,
        output req1_valid, req1_addr, req1_data,
        input  req0_ready, req1_ready,
        input  Rd, Wdata, w_enable, grant_id, r0_drop, busy
    );

    modport slave (
        input  req0_valid, req0_addr, req0_data,
        input  req1_valid, req1_addr, req1_data,
        output req0_ready, req1_ready,
        output Rd, Wdata, w_enable, grant_id, r0_drop, busy
    );

endinterface

// File: rtl/reg_file_wr_arbiter_fifo.sv
// Per-requester FIFO; pointers carry one extra wrap bit so the
// occupancy is simply wr_ptr - rd_ptr.
module wr_fifo
    import reg_arb_pkg::*;
#(
    parameter int  DEPTH = 2,
    parameter type T     = wr_req_t
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  logic pop,
    input  T     wdata,
    output T     rdata,
    output logic full,
    output logic empty
);

    localparam int PW = $clog2(DEPTH);

    logic [PW:0] wr_ptr;
    logic [PW:0] rd_ptr;
    logic [PW:0] count;
    logic        do_push;
    logic        do_pop;
    T            mem [DEPTH];

    assign count   = wr_ptr - rd_ptr;
    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr[PW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[PW-1:0]] <= wdata;
    end

endmodule

// File: rtl/reg_file_wr_arbiter.sv
// Round-robin share of the single reg_file write port between ALU
// writeback (port 0) and the load/IO path (port 1).
module reg_file_wr_arbiter
    import reg_arb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    reg_file_wr_arbiter_if.slave  bus
);

    wr_req_t in0, in1, head0, head1, head;
    logic    full0, full1, empty0, empty1;
    logic    gnt0, gnt1, any_gnt, drop;
    logic    last_grant;

    logic [ADDR_W-1:0] rd_q;
    logic [N-1:0]      wd_q;
    logic              we_q, gid_q, drop_q;

    assign in0 = '{addr: bus.req0_addr, data: bus.req0_data};
    assign in1 = '{addr: bus.req1_addr, data: bus.req1_data};

    assign bus.req0_ready = !full0 && !reset;
    assign bus.req1_ready = !full1 && !reset;

    wr_fifo #(.DEPTH(DEPTH), .T(wr_req_t)) u_fifo0 (
        .clk   (clk),
        .reset (reset),
        .push  (bus.req0_valid && bus.req0_ready),
        .pop   (gnt0),
        .wdata (in0),
        .rdata (head0),
        .full  (full0),
        .empty (empty0)
    );

    wr_fifo #(.DEPTH(DEPTH), .T(wr_req_t)) u_fifo1 (
        .clk   (clk),
        .reset (reset),
        .push  (bus.req1_valid && bus.req1_ready),
        .pop   (gnt1),
        .wdata (in1),
        .rdata (head1),
        .full  (full1),
        .empty (empty1)
    );

    // Under contention the port that did not win last time goes next.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!empty0 && (empty1 || last_grant))
            gnt0 = 1'b1;
        else if (!empty1)
            gnt1 = 1'b1;
    end

    assign any_gnt = gnt0 || gnt1;
    assign head    = gnt1 ? head1 : head0;
    assign drop    = (head.addr == ZERO_REG);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_q       <= '0;
            wd_q       <= '0;
            we_q       <= 1'b0;
            gid_q      <= 1'b0;
            drop_q     <= 1'b0;
            last_grant <= 1'b1;
        end else if (any_gnt) begin
            gid_q      <= gnt1;
            last_grant <= gnt1;
            we_q       <= !drop;
            drop_q     <= drop;
            rd_q       <= drop ? '0 : head.addr;
            wd_q       <= drop ? '0 : head.data;
        end else begin
            we_q       <= 1'b0;
            drop_q     <= 1'b0;
        end
    end

    assign bus.Rd       = rd_q;
    assign bus.Wdata    = wd_q;
    assign bus.w_enable = we_q;
    assign bus.grant_id = gid_q;
    assign bus.r0_drop  = drop_q;
    assign bus.busy     = !empty0 || !empty1 || we_q;

endmodule

// File: tb/tb_reg_file_wr_arbiter.sv
// Directed bench for reg_file_wr_arbiter with a queue-based reference
// model checked every cycle plus literal per-scenario expectations.
module tb_reg_file_wr_arbiter;
    import reg_arb_pkg::*;

    localparam int DEPTH = 2;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    reg_file_wr_arbiter_if bus();

    reg_file_wr_arbiter #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    wr_req_t s0[$], s1[$];
    wr_req_t mq0[$], mq1[$];

    int                mlast = 1;
    logic              e_we  = 1'b0;
    logic              e_drop = 1'b0;
    logic [ADDR_W-1:0] e_rd  = '0;
    logic [N-1:0]      e_wd  = '0;
    logic              e_gid = 1'b0;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int acc_cyc0 = 0;
    bit stall0   = 1'b0;
    int drops    = 0;

    typedef struct {
        int gid;
        int rd;
        int wd;
        int cyc;
    } ent_t;
    ent_t wlog[$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic apply();
        bus.req0_valid = (s0.size() > 0);
        bus.req1_valid = (s1.size() > 0);
        if (s0.size() > 0) begin
            bus.req0_addr = s0[0].addr;
            bus.req0_data = s0[0].data;
        end
        if (s1.size() > 0) begin
            bus.req1_addr = s1[0].addr;
            bus.req1_data = s1[0].data;
        end
    endtask

    // Stimulus driver: retire a stimulus entry when the DUT accepted it.
    initial begin
        bus.req0_valid = 1'b0;
        bus.req0_addr  = '0;
        bus.req0_data  = '0;
        bus.req1_valid = 1'b0;
        bus.req1_addr  = '0;
        bus.req1_data  = '0;
        forever begin
            @(posedge clk);
            if (!reset) begin
                if (bus.req0_valid && bus.req0_ready) begin
                    void'(s0.pop_front());
                    acc_cyc0 = cyc;
                end
                if (bus.req0_valid && !bus.req0_ready) stall0 = 1'b1;
                if (bus.req1_valid && bus.req1_ready) void'(s1.pop_front());
            end
            #1;
            apply();
        end
    end

    // Reference model: two bounded queues and a fairness bit.
    initial begin
        bit      a0, a1, g;
        wr_req_t h;
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                mq0.delete();
                mq1.delete();
                mlast  = 1;
                e_we   = 1'b0;
                e_drop = 1'b0;
                e_rd   = '0;
                e_wd   = '0;
                e_gid  = 1'b0;
            end else begin
                a0 = bus.req0_valid && (mq0.size() < DEPTH);
                a1 = bus.req1_valid && (mq1.size() < DEPTH);
                if (mq0.size() > 0 || mq1.size() > 0) begin
                    if (mq0.size() > 0 && mq1.size() > 0)
                        g = (mlast == 0);
                    else
                        g = (mq1.size() > 0);
                    h     = g ? mq1.pop_front() : mq0.pop_front();
                    e_gid = g;
                    mlast = g ? 1 : 0;
                    if (h.addr == 0) begin
                        e_we = 1'b0; e_drop = 1'b1; e_rd = '0; e_wd = '0;
                    end else begin
                        e_we = 1'b1; e_drop = 1'b0; e_rd = h.addr; e_wd = h.data;
                    end
                end else begin
                    e_we   = 1'b0;
                    e_drop = 1'b0;
                end
                if (a0) mq0.push_back('{addr: bus.req0_addr, data: bus.req0_data});
                if (a1) mq1.push_back('{addr: bus.req1_addr, data: bus.req1_data});
            end
        end
    end

    // Per-cycle compare against the model, plus a log of real writes.
    initial begin
        forever begin
            @(negedge clk);
            chk("req0_ready", bus.req0_ready, !reset && mq0.size() < DEPTH);
            chk("req1_ready", bus.req1_ready, !reset && mq1.size() < DEPTH);
            chk("w_enable", bus.w_enable, e_we);
            chk("r0_drop", bus.r0_drop, e_drop);
            chk("Rd", bus.Rd, e_rd);
            chk("Wdata", bus.Wdata, e_wd);
            chk("grant_id", bus.grant_id, e_gid);
            chk("busy", bus.busy, mq0.size() > 0 || mq1.size() > 0 || e_we);
            if (bus.w_enable)
                wlog.push_back('{int'(bus.grant_id), int'(bus.Rd),
                                 int'(bus.Wdata), cyc});
            if (bus.r0_drop) drops++;
        end
    end

    task automatic wait_idle(input int maxc);
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            #1;
            n++;
            if (s0.size() == 0 && s1.size() == 0 && !bus.req0_valid &&
                !bus.req1_valid && !bus.busy && !bus.w_enable &&
                !bus.r0_drop)
                break;
            if (n >= maxc) begin
                vectors++;
                miscompares++;
                $display("FAIL idle_timeout: got busy after %0d cycles expected idle", n);
                break;
            end
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 reset = 1'b1;
        s0.delete();
        s1.delete();
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b0;
    endtask

    initial begin
        int er[8];
        int n5, last5, n;
        er = '{1, 31, 2, 30, 3, 29, 4, 28};

        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("ready0_after_release", bus.req0_ready, 1);
        chk("busy_after_release", bus.busy, 0);

        // Single write on port 0
        @(negedge clk);
        wlog.delete();
        s0.push_back('{addr: 5'd22, data: 8'd133});
        wait_idle(20);
        chk("single_count", wlog.size(), 1);
        chk("single_gid", wlog[0].gid, 0);
        chk("single_rd", wlog[0].rd, 22);
        chk("single_wd", wlog[0].wd, 133);
        chk("single_latency", wlog[0].cyc - acc_cyc0, 2);

        // Zero register on port 1
        wlog.delete();
        drops = 0;
        s1.push_back('{addr: 5'd0, data: 8'd133});
        wait_idle(20);
        chk("zero_drops", drops, 1);
        chk("zero_writes", wlog.size(), 0);

        // Contention
        wlog.delete();
        for (int i = 0; i < 4; i++) begin
            s0.push_back('{addr: 5'(i + 1), data: 8'((i + 1) * 3)});
            s1.push_back('{addr: 5'(31 - i), data: 8'((31 - i) * 3)});
        end
        wait_idle(40);
        chk("cont_count", wlog.size(), 8);
        for (int i = 0; i < 8 && i < wlog.size(); i++) begin
            chk("cont_rd", wlog[i].rd, er[i]);
            chk("cont_gid", wlog[i].gid, i % 2);
        end
        chk("cont_span", wlog[7].cyc - wlog[0].cyc, 7);

        // Backpressure
        wlog.delete();
        stall0 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            s0.push_back('{addr: 5'd5, data: 8'(10 + i)});
            s1.push_back('{addr: 5'd6, data: 8'(100 + i)});
        end
        wait_idle(60);
        n5 = 0;
        last5 = -1;
        foreach (wlog[i]) if (wlog[i].rd == 5) begin
            n5++;
            last5 = wlog[i].wd;
        end
        chk("bp_stall0", stall0, 1);
        chk("bp_total", wlog.size(), 12);
        chk("bp_addr5_count", n5, 6);
        chk("bp_addr5_last", last5, 15);

        // Same-address race straight after reset
        do_reset();
        @(negedge clk);
        wlog.delete();
        s0.push_back('{addr: 5'd9, data: 8'd33});
        s1.push_back('{addr: 5'd9, data: 8'd233});
        wait_idle(20);
        chk("race_count", wlog.size(), 2);
        chk("race_first_gid", wlog[0].gid, 0);
        chk("race_first_wd", wlog[0].wd, 33);
        chk("race_last_rd", wlog[1].rd, 9);
        chk("race_last_wd", wlog[1].wd, 233);

        // Reset while both FIFOs hold entries
        for (int i = 0; i < 3; i++) begin
            s0.push_back('{addr: 5'(10 + i), data: 8'(i + 1)});
            s1.push_back('{addr: 5'(20 + i), data: 8'(i + 50)});
        end
        n = 0;
        while (!bus.w_enable && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        @(posedge clk);
        #1;
        chk("mid_we_before", bus.w_enable, 1);
        #1 reset = 1'b1;
        s0.delete();
        s1.delete();
        #1;
        chk("mid_we_cancel", bus.w_enable, 0);
        chk("mid_busy_cancel", bus.busy, 0);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("mid_ready0", bus.req0_ready, 1);
        chk("mid_ready1", bus.req1_ready, 1);
        chk("mid_busy", bus.busy, 0);
        wlog.delete();
        s0.push_back('{addr: 5'd7, data: 8'd1});
        s1.push_back('{addr: 5'd8, data: 8'd2});
        wait_idle(20);
        chk("post_count", wlog.size(), 2);
        chk("post_first_gid", wlog[0].gid, 0);
        chk("post_first_rd", wlog[0].rd, 7);
        chk("post_second_gid", wlog[1].gid, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
